// File: rtl/fpga_cfg_loader_pkg.sv
// Purpose: shared types and defaults for the framed configuration loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpga_cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HUNT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_ERROR = 3'd4
    } cfg_state_e;

    localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
    localparam logic [7:0] DEF_CRC_POLY  = 8'h07;
    localparam int         HUNT_LIMIT    = 64;
    localparam int         HUNT_CNT_W    = $clog2(HUNT_LIMIT + 1);

    // One MSB-first CRC step: feedback is the outgoing MSB xor the incoming bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic       din,
                                             input logic [7:0] poly);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Purpose: the four-pin programming port plus the serial readback pin.
// Latency: n/a (wires only).
// Backpressure: none; the pin protocol is free-running and paced by prog_clk.
interface fpga_cfg_loader_if;
    logic prog_clk;
    logic prog_rst;
    logic prog_en;
    logic prog_din;
    logic prog_dout;

    modport master (output prog_clk, prog_rst, prog_en, prog_din, input  prog_dout);
    modport slave  (input  prog_clk, prog_rst, prog_en, prog_din, output prog_dout);
endinterface

// File: rtl/fpga_cfg_loader_crc8.sv
// Purpose: serial CRC-8, one bit per enabled clk, MSB first, init zero.
// Latency: crc_o reflects a bit one clk after it is presented with en_i.
// Backpressure: none; clr_i has priority over en_i.
module cfg_crc8
    import fpga_cfg_loader_pkg::*;
#(
    parameter logic [7:0] POLY = DEF_CRC_POLY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       din_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: clear, step, or hold.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = crc8_step(crc_q, din_i, POLY);
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Purpose: framed, CRC-checked serial loader committing a shadow register to cfg_out atomically.
// Latency: pin edge to sample is 3 clk; commit lands on the clk edge that samples the 8th CRC bit.
// Backpressure: none; prog_clk phases must each last at least 3 clk or bits are lost.
module fpga_cfg_loader
    import fpga_cfg_loader_pkg::*;
#(
    parameter int         CFG_BITS  = 64,
    parameter logic [7:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter logic [7:0] CRC_POLY  = DEF_CRC_POLY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpga_cfg_loader_if.slave     prog,
    output logic [CFG_BITS-1:0]  cfg_out,
    output logic                 cfg_valid,
    output logic                 cfg_commit,
    output logic                 cfg_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CFG_BITS + 1);
    localparam int PTR_W = $clog2(CFG_BITS);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(CFG_BITS - 1);

    // Pin order in the synchroniser vector: {prog_clk, prog_rst, prog_en, prog_din}.
    logic [3:0] pin_s1_q, pin_s2_q;
    logic       pclk_prev_q, en_prev_q;
    logic       pclk_s, prst_s, en_s, din_s;
    logic       sample, en_rise, en_fall;

    cfg_state_e state_q, state_d;

    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [HUNT_CNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
    logic [7:0]            window_q, window_d;
    logic [7:0]            rx_crc_q, rx_crc_d;
    logic [CFG_BITS-1:0]   shadow_q, shadow_d;
    logic [CFG_BITS-1:0]   cfg_out_q, cfg_out_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  commit_q, commit_d;
    logic                  error_q, error_d;

    logic [7:0] window_nxt, rx_nxt, crc_calc;
    logic       sync_hit, hunt_last, load_last, chk_last, crc_ok;
    logic       hunt_clr, commit_go, err_set, crc_en;

    // Two-flop synchronisers on every pin plus edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_s1_q    <= 4'b0000;
            pin_s2_q    <= 4'b0000;
            pclk_prev_q <= 1'b0;
            en_prev_q   <= 1'b0;
        end else begin
            pin_s1_q    <= {prog.prog_clk, prog.prog_rst, prog.prog_en, prog.prog_din};
            pin_s2_q    <= pin_s1_q;
            pclk_prev_q <= pin_s2_q[3];
            en_prev_q   <= pin_s2_q[1];
        end
    end

    assign pclk_s  = pin_s2_q[3];
    assign prst_s  = pin_s2_q[2];
    assign en_s    = pin_s2_q[1];
    assign din_s   = pin_s2_q[0];
    assign sample  = pclk_s & ~pclk_prev_q;
    assign en_rise = en_s & ~en_prev_q;
    assign en_fall = ~en_s & en_prev_q;

    assign window_nxt = {window_q[6:0], din_s};
    assign rx_nxt     = {rx_crc_q[6:0], din_s};
    assign sync_hit   = (window_nxt == SYNC_WORD);
    assign hunt_last  = (hunt_cnt_q == HUNT_CNT_W'(HUNT_LIMIT - 1));
    assign load_last  = (bit_cnt_q == CNT_W'(CFG_BITS - 1));
    assign chk_last   = (bit_cnt_q == CNT_W'(7));
    assign crc_ok     = (rx_nxt == crc_calc);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; an 8th CRC bit beats a simultaneous prog_en fall.
    always_comb begin
        state_d = state_q;
        if (prst_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (en_rise) state_d = ST_HUNT;
                ST_HUNT: begin
                    if (en_fall)                      state_d = ST_IDLE;
                    else if (sample && sync_hit)      state_d = ST_LOAD;
                    else if (sample && hunt_last)     state_d = ST_ERROR;
                end
                ST_LOAD: begin
                    if (en_fall)                      state_d = ST_IDLE;
                    else if (sample && load_last)     state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (sample && chk_last)           state_d = (crc_ok || en_fall) ? ST_IDLE : ST_ERROR;
                    else if (en_fall)                 state_d = ST_IDLE;
                end
                ST_ERROR: if (en_fall) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: busy flag and datapath strobes.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        hunt_clr  = !prst_s && (state_q == ST_IDLE) && en_rise;
        commit_go = !prst_s && (state_q == ST_CHECK) && sample && chk_last && crc_ok;
        err_set   = !prst_s &&
                    (((state_q == ST_HUNT) && !en_fall && sample && !sync_hit && hunt_last) ||
                     ((state_q == ST_CHECK) && sample && chk_last && !crc_ok));
        crc_en    = !prst_s && (state_q == ST_LOAD) && !en_fall && sample;
    end

    cfg_crc8 #(.POLY(CRC_POLY)) u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (crc_en),
        .clr_i (hunt_clr),
        .din_i (din_s),
        .crc_o (crc_calc)
    );

    // Datapath next state: hunt window, shadow shift, received CRC, readback pointer, flags.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        hunt_cnt_d = hunt_cnt_q;
        window_d   = window_q;
        rx_crc_d   = rx_crc_q;
        shadow_d   = shadow_q;
        cfg_out_d  = cfg_out_q;
        ptr_d      = ptr_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        commit_d   = 1'b0;
        error_d    = error_q;

        if (hunt_clr) begin
            bit_cnt_d  = '0;
            hunt_cnt_d = '0;
            window_d   = 8'h00;
            rx_crc_d   = 8'h00;
        end else if (sample && !prst_s) begin
            case (state_q)
                ST_HUNT: begin
                    window_d   = window_nxt;
                    hunt_cnt_d = hunt_cnt_q + HUNT_CNT_W'(1);
                end
                ST_LOAD: begin
                    shadow_d  = {shadow_q[CFG_BITS-2:0], din_s};
                    dout_d    = shadow_q[CFG_BITS-1];
                    bit_cnt_d = load_last ? '0 : bit_cnt_q + CNT_W'(1);
                end
                ST_CHECK: begin
                    rx_crc_d  = rx_nxt;
                    dout_d    = shadow_q[CFG_BITS-1];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                ST_IDLE: begin
                    if (!en_s) ptr_d = (ptr_q == '0) ? PTR_TOP : ptr_q - PTR_W'(1);
                end
                default: ;
            endcase
        end

        // Outside IDLE the pointer is parked so readback always restarts at the MSB.
        if (state_q != ST_IDLE) ptr_d = PTR_TOP;

        if (commit_go) begin
            cfg_out_d = shadow_q;
            valid_d   = 1'b1;
            commit_d  = 1'b1;
        end

        if (prst_s || commit_go) error_d = 1'b0;
        else if (err_set)        error_d = 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            hunt_cnt_q <= '0;
            window_q   <= 8'h00;
            rx_crc_q   <= 8'h00;
            shadow_q   <= '0;
            cfg_out_q  <= '0;
            ptr_q      <= PTR_TOP;
            dout_q     <= 1'b0;
            valid_q    <= 1'b0;
            commit_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            hunt_cnt_q <= hunt_cnt_d;
            window_q   <= window_d;
            rx_crc_q   <= rx_crc_d;
            shadow_q   <= shadow_d;
            cfg_out_q  <= cfg_out_d;
            ptr_q      <= ptr_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            commit_q   <= commit_d;
            error_q    <= error_d;
        end
    end

    // Serial out: shadow pass-through while loading, readback in idle, quiet otherwise.
    always_comb begin
        case (state_q)
            ST_IDLE:           prog.prog_dout = en_s ? 1'b0 : cfg_out_q[ptr_q];
            ST_LOAD, ST_CHECK: prog.prog_dout = dout_q;
            default:           prog.prog_dout = 1'b0;
        endcase
    end

    assign cfg_out    = cfg_out_q;
    assign cfg_valid  = valid_q;
    assign cfg_commit = commit_q;
    assign cfg_error  = error_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Purpose: directed self-checking bench for the framed configuration loader (16-bit payload).
// Latency: drives prog_clk at 8 clk per bit; commits are scoreboarded as they appear.
// Backpressure: n/a.
module tb_fpga_cfg_loader;

    localparam int         CFG_BITS = 16;
    localparam logic [7:0] SYNC     = 8'hA5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CFG_BITS-1:0] cfg_out;
    logic                cfg_valid, cfg_commit, cfg_error, busy;

    int checks   = 0;
    int failures = 0;
    int commits  = 0;
    logic [CFG_BITS-1:0] exp_q[$];

    fpga_cfg_loader_if pif();

    fpga_cfg_loader #(.CFG_BITS(CFG_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog       (pif),
        .cfg_out    (cfg_out),
        .cfg_valid  (cfg_valid),
        .cfg_commit (cfg_commit),
        .cfg_error  (cfg_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        pif.prog_clk = 1'b0;
        pif.prog_din = b;
        clks(4);
        pif.prog_clk = 1'b1;
        clks(4);
    endtask

    task automatic send_bits(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic send_frame(input logic [15:0] payload, input logic [7:0] crc);
        pif.prog_en = 1'b1;
        clks(4);
        send_bits({32'h0, SYNC, payload, crc}, 32);
        clks(6);
    endtask

    task automatic drop_en();
        pif.prog_en = 1'b0;
        clks(6);
    endtask

    // Byte-wise reference CRC-8 (poly 0x07, init 0, MSB first).
    function automatic logic [7:0] crc_model(input logic [15:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 1; b >= 0; b--) begin
            c = c ^ d[b*8 +: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Scoreboard: every commit pulse must match the next expected configuration.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cfg_commit === 1'b1) begin
            commits++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL commit_unexpected observed=%0h expected=none", cfg_out);
            end
            if (exp_q.size() != 0) begin
                logic [CFG_BITS-1:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (cfg_out === e) else begin
                    failures++;
                    $error("FAIL commit_data observed=%0h expected=%0h", cfg_out, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CFG_BITS-1:0] rb;
        rst_n        = 1'b0;
        pif.prog_clk = 1'b0;
        pif.prog_rst = 1'b0;
        pif.prog_en  = 1'b0;
        pif.prog_din = 1'b0;
        clks(3);
        chk("rst_cfg_out", cfg_out, 0);
        chk("rst_valid", cfg_valid, 0);
        chk("rst_commit", cfg_commit, 0);
        chk("rst_error", cfg_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", pif.prog_dout, 0);
        rst_n = 1'b1;
        clks(4);

        // Good frame with the known CRC.
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, 8'hF1);
        chk("t1_cfg_out", cfg_out, 16'h1234);
        chk("t1_valid", cfg_valid, 1);
        chk("t1_error", cfg_error, 0);
        chk("t1_busy", busy, 0);
        chk("t1_one_commit", commits, 1);
        chk("t1_sb_empty", exp_q.size(), 0);
        drop_en();

        // Readback: bit shown just before each rising edge, MSB first, wrapping.
        rb = 16'h1234;
        for (int i = 0; i < 17; i++) begin
            pif.prog_clk = 1'b0;
            clks(4);
            chk($sformatf("rb_bit%0d", i), pif.prog_dout, rb[CFG_BITS-1 - (i % CFG_BITS)]);
            pif.prog_clk = 1'b1;
            clks(4);
        end

        // Bad CRC.
        send_frame(16'h1234, 8'hF0);
        chk("t2_error", cfg_error, 1);
        chk("t2_cfg_out", cfg_out, 16'h1234);
        chk("t2_busy_err", busy, 1);
        chk("t2_no_commit", commits, 1);
        drop_en();
        chk("t2_busy_idle", busy, 0);
        chk("t2_error_sticky", cfg_error, 1);

        // Sync hunt through noise.
        exp_q.push_back(16'hBEEF);
        pif.prog_en = 1'b1;
        clks(4);
        send_bits(64'b10110, 5);
        send_bits({32'h0, SYNC, 16'hBEEF, crc_model(16'hBEEF)}, 32);
        clks(6);
        chk("t3_commit", commits, 2);
        chk("t3_cfg_out", cfg_out, 16'hBEEF);
        chk("t3_error_clr", cfg_error, 0);
        drop_en();

        // Hunt limit: 63 zeros still hunting, the 64th gives up.
        pif.prog_en = 1'b1;
        clks(4);
        for (int i = 0; i < 63; i++) send_bit(1'b0);
        chk("t3_hunt63_error", cfg_error, 0);
        chk("t3_hunt63_busy", busy, 1);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        chk("t3_hunt_error", cfg_error, 1);
        chk("t3_hunt_busy", busy, 1);

        // Soft reset during ERROR.
        pif.prog_rst = 1'b1;
        clks(6);
        pif.prog_rst = 1'b0;
        clks(4);
        chk("t6_prst_error", cfg_error, 0);
        chk("t6_prst_busy", busy, 0);
        chk("t6_prst_cfg_out", cfg_out, 16'hBEEF);
        chk("t6_prst_valid", cfg_valid, 1);
        drop_en();

        // Abort after 9 payload bits, then a good frame.
        pif.prog_en = 1'b1;
        clks(4);
        send_bits({56'h0, SYNC}, 8);
        send_bits(64'(16'h5555 >> 7), 9);
        chk("t4_busy_load", busy, 1);
        drop_en();
        chk("t4_busy", busy, 0);
        chk("t4_cfg_out", cfg_out, 16'hBEEF);
        chk("t4_error", cfg_error, 0);
        chk("t4_no_commit", commits, 2);
        exp_q.push_back(16'h0F0F);
        send_frame(16'h0F0F, crc_model(16'h0F0F));
        chk("t4_cfg_out_new", cfg_out, 16'h0F0F);
        chk("t4_commit", commits, 3);
        drop_en();

        // Async reset mid-load.
        pif.prog_en = 1'b1;
        clks(4);
        send_bits({56'h0, SYNC}, 8);
        send_bits(64'b10101, 5);
        chk("t6_busy_load", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_arst_cfg_out", cfg_out, 0);
        chk("t6_arst_valid", cfg_valid, 0);
        chk("t6_arst_commit", cfg_commit, 0);
        chk("t6_arst_error", cfg_error, 0);
        chk("t6_arst_busy", busy, 0);
        chk("t6_arst_dout", pif.prog_dout, 0);
        pif.prog_en  = 1'b0;
        pif.prog_clk = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(6);

        // Recovery after reset.
        exp_q.push_back(16'hC3A5);
        send_frame(16'hC3A5, crc_model(16'hC3A5));
        chk("t6_recover_cfg_out", cfg_out, 16'hC3A5);
        chk("t6_recover_valid", cfg_valid, 1);
        drop_en();

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
